// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt controller: edge-latched IRQs, fixed-priority entry, ELR capture
module exc_ctrl #(
    parameter int NIRQ = 4,
    parameter int N    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    PC,
    input  logic            NotAnInstr,
    input  logic [NIRQ-1:0] ExtIRQ,
    input  logic [NIRQ-1:0] IrqMask,
    input  logic            ExcAck,
    input  logic            ERet,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic [NIRQ-1:0] ExtIAck,
    output logic [N-1:0]    ELR,
    output logic            InHandler,
    output logic            DblFault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] irq_q;
    logic            armed_q;
    logic [NIRQ-1:0] pending_q;
    logic [3:0]      cause_q;
    logic [N-1:0]    elr_q;
    logic            dbl_q;
    logic [NIRQ-1:0] ack_q;

    logic [NIRQ-1:0] irq_set;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] ack_vec;
    logic [2:0]      sel;
    logic            take;
    logic [3:0]      new_cause;
    logic            do_ack;

    // armed_q suppresses edge detection for the first cycle after reset, so a
    // level held through reset is taken as the baseline rather than a new edge.
    assign irq_set  = ExtIRQ & ~irq_q & ~IrqMask & {NIRQ{armed_q}};
    assign eligible = pending_q & ~IrqMask;

    always_comb begin
        sel = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NIRQ; i++) begin
            ack_vec[i] = cause_q[3] && (cause_q[2:0] == 3'(i));
        end
    end

    assign take      = NotAnInstr || (|eligible);
    assign new_cause = NotAnInstr ? 4'h2 : {1'b1, sel};
    assign do_ack    = (state_q == REQ) && ExcAck;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = REQ;
            REQ:     if (ExcAck) state_d = HANDLER;
            HANDLER: if (ERet) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            cause_q   <= 4'h0;
            elr_q     <= '0;
            dbl_q     <= 1'b0;
            ack_q     <= '0;
        end else begin
            irq_q   <= ExtIRQ;
            armed_q <= 1'b1;
            // A new edge in the acknowledge cycle wins over the clear.
            pending_q <= (pending_q & ~(do_ack ? ack_vec : '0)) | irq_set;
            ack_q     <= do_ack ? ack_vec : '0;
            if (state_q == IDLE && take) begin
                cause_q <= new_cause;
                elr_q   <= PC;
            end
            if (state_q == HANDLER && ERet) cause_q <= 4'h0;
            if (state_q == HANDLER && NotAnInstr) dbl_q <= 1'b1;
        end
    end

    assign Exc       = (state_q == REQ);
    assign InHandler = (state_q == HANDLER);
    assign EStatus   = cause_q;
    assign ELR       = elr_q;
    assign ExtIAck   = ack_q;
    assign DblFault  = dbl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] PC;
    logic        NotAnInstr;
    logic [3:0]  ExtIRQ;
    logic [3:0]  IrqMask;
    logic        ExcAck;
    logic        ERet;
    logic        Exc;
    logic [3:0]  EStatus;
    logic [3:0]  ExtIAck;
    logic [63:0] ELR;
    logic        InHandler;
    logic        DblFault;

    int checks   = 0;
    int failures = 0;

    exc_ctrl #(.NIRQ(4), .N(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .NotAnInstr (NotAnInstr),
        .ExtIRQ     (ExtIRQ),
        .IrqMask    (IrqMask),
        .ExcAck     (ExcAck),
        .ERet       (ERet),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .ExtIAck    (ExtIAck),
        .ELR        (ELR),
        .InHandler  (InHandler),
        .DblFault   (DblFault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_exc"}, {63'd0, Exc}, 64'd0);
        chk({tag, "_estatus"}, {60'd0, EStatus}, 64'd0);
        chk({tag, "_iack"}, {60'd0, ExtIAck}, 64'd0);
        chk({tag, "_inh"}, {63'd0, InHandler}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; PC = '0; NotAnInstr = 1'b0; ExtIRQ = '0; IrqMask = '0;
        ExcAck = 1'b0; ERet = 1'b0;
        step(); step();
        reset = 1'b0;
        chk_idle("rst");
        chk("rst_elr", ELR, 64'd0);
        chk("rst_dbl", {63'd0, DblFault}, 64'd0);
        step(); step();

        // single channel 2 request
        PC = 64'h1000; ExtIRQ = 4'b0100;
        step();
        chk("c2_pend_noexc", {63'd0, Exc}, 64'd0);
        step();
        chk("c2_exc", {63'd0, Exc}, 64'd1);
        chk("c2_estatus", {60'd0, EStatus}, 64'hA);
        chk("c2_elr", ELR, 64'h1000);
        PC = 64'h2000;
        step();
        chk("c2_elr_lock", ELR, 64'h1000);
        chk("c2_exc_hold", {63'd0, Exc}, 64'd1);
        ExcAck = 1'b1; step(); ExcAck = 1'b0;
        chk("c2_iack", {60'd0, ExtIAck}, 64'h4);
        chk("c2_inh", {63'd0, InHandler}, 64'd1);
        chk("c2_exc_low", {63'd0, Exc}, 64'd0);
        chk("c2_est_hold", {60'd0, EStatus}, 64'hA);
        step();
        chk("c2_iack_pulse", {60'd0, ExtIAck}, 64'h0);
        ERet = 1'b1; step(); ERet = 1'b0;
        chk_idle("c2_eret");
        ExtIRQ = 4'b0000; step(); step();
        chk("c2_no_retake", {63'd0, Exc}, 64'd0);

        // channels 1 and 3 together: 1 first, then 3
        ExtIRQ = 4'b1010; step(); step();
        chk("c13_first", {60'd0, EStatus}, 64'h9);
        ExcAck = 1'b1; step(); ExcAck = 1'b0;
        chk("c13_iack1", {60'd0, ExtIAck}, 64'h2);
        ERet = 1'b1; step(); ERet = 1'b0;
        chk("c13_idle_est", {60'd0, EStatus}, 64'h0);
        step();
        chk("c13_second", {60'd0, EStatus}, 64'hB);
        chk("c13_exc", {63'd0, Exc}, 64'd1);
        ExcAck = 1'b1; step(); ExcAck = 1'b0;
        chk("c13_iack3", {60'd0, ExtIAck}, 64'h8);
        ERet = 1'b1; step(); ERet = 1'b0;
        ExtIRQ = 4'b0000; step();

        // undefined instruction outranks pending channel 0
        ExtIRQ = 4'b0001; step();
        NotAnInstr = 1'b1; PC = 64'h3000; step(); NotAnInstr = 1'b0;
        chk("ud_est", {60'd0, EStatus}, 64'h2);
        chk("ud_elr", ELR, 64'h3000);
        ExcAck = 1'b1; step(); ExcAck = 1'b0;
        chk("ud_iack", {60'd0, ExtIAck}, 64'h0);
        chk("ud_inh", {63'd0, InHandler}, 64'd1);
        ERet = 1'b1; step(); ERet = 1'b0;
        step();
        chk("ud_c0_est", {60'd0, EStatus}, 64'h8);
        ExcAck = 1'b1; step(); ExcAck = 1'b0;
        chk("ud_c0_iack", {60'd0, ExtIAck}, 64'h1);

        // double fault inside handler
        chk("df_pre", {63'd0, DblFault}, 64'd0);
        NotAnInstr = 1'b1; step(); NotAnInstr = 1'b0;
        chk("df_set", {63'd0, DblFault}, 64'd1);
        chk("df_inh", {63'd0, InHandler}, 64'd1);
        ERet = 1'b1; step(); ERet = 1'b0;
        chk("df_sticky", {63'd0, DblFault}, 64'd1);
        chk("df_idle", {63'd0, InHandler}, 64'd0);
        ExtIRQ = 4'b0000; step();

        // masked edge is dropped
        IrqMask = 4'b0010; ExtIRQ = 4'b0010; step(); step();
        chk("mask_noexc", {63'd0, Exc}, 64'd0);
        IrqMask = 4'b0000; step(); step();
        chk("unmask_noexc", {63'd0, Exc}, 64'd0);
        ExtIRQ = 4'b0000; step();

        // reset mid-REQ with ExcAck, held level must not retrigger
        ExtIRQ = 4'b0100; step(); step();
        chk("rq_exc", {63'd0, Exc}, 64'd1);
        reset = 1'b1; ExcAck = 1'b1; step(); reset = 1'b0; ExcAck = 1'b0;
        chk_idle("rq_rst");
        chk("rq_rst_elr", ELR, 64'd0);
        chk("rq_rst_dbl", {63'd0, DblFault}, 64'd0);
        step(); step(); step();
        chk("rq_held_noexc", {63'd0, Exc}, 64'd0);
        ExtIRQ = 4'b0000; step();
        ExtIRQ = 4'b0100; step(); step();
        chk("rq_new_edge", {60'd0, EStatus}, 64'hA);

        // new edge in the acknowledge cycle keeps the channel pending
        ExtIRQ = 4'b0000; step();
        ExtIRQ = 4'b0100; ExcAck = 1'b1; step(); ExcAck = 1'b0;
        chk("sw_iack", {60'd0, ExtIAck}, 64'h4);
        ERet = 1'b1; step(); ERet = 1'b0;
        step();
        chk("sw_retake", {63'd0, Exc}, 64'd1);
        chk("sw_est", {60'd0, EStatus}, 64'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
